// File: rtl/camera_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// camera_init_sequencer_if
//
// Groups the configuration-table port and the SCCB write handshake that the
// camera init sequencer drives.
//
//   table_addr    : table index presented by the sequencer
//   table_data    : {cmd[1:0], reg_addr[RW-1:0], data[7:0]}, valid one
//                   enabled cycle after table_addr
//   sccb_start    : one-enabled-cycle write request
//   sccb_reg_addr : sensor register address for the pending write
//   sccb_data     : register data for the pending write
//   sccb_ready    : SCCB engine idle
//
// Modports: master = sequencer side, slave = table ROM / SCCB engine side.
// ---------------------------------------------------------------------------
interface camera_init_sequencer_if #(
   parameter int RW = 8,
   parameter int AW = 8
);
   logic [AW-1:0]   table_addr;
   logic [RW+9:0]   table_data;
   logic            sccb_start;
   logic [RW-1:0]   sccb_reg_addr;
   logic [7:0]      sccb_data;
   logic            sccb_ready;

   modport master (
      output table_addr,
      input  table_data,
      output sccb_start,
      output sccb_reg_addr,
      output sccb_data,
      input  sccb_ready
   );

   modport slave (
      input  table_addr,
      output table_data,
      input  sccb_start,
      input  sccb_reg_addr,
      input  sccb_data,
      output sccb_ready
   );
endinterface

// File: rtl/camera_init_sequencer.sv
// ---------------------------------------------------------------------------
// camera_init_sequencer
//
// Powers up an image sensor (PWDN, then RESET, then settle), generates XCLK
// with a programmable divider, then walks a register table of WRITE / DELAY /
// END / NOP commands, issuing each WRITE to an external SCCB engine through a
// start/ready handshake. Reports done/error to the capture pipeline.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clk_en        : every register advances only on cycles where this is 1
//   restart       : re-run the table from DONE (no power sequencing)
//   bus           : table port + SCCB handshake (master modport)
//   busy / done   : sequence running / finished (success or error)
//   error         : SCCB timeout or table overrun without END
//   write_count   : SCCB writes issued during the current run
//   reset / pwdn  : sensor RESET (active-low) and PWDN (active-high)
//   xclk          : sensor clock
// ---------------------------------------------------------------------------
module camera_init_sequencer #(
   parameter int CLK_FREQ       = 25000000,
   parameter int REG_ADDR_BYTES = 1,
   parameter int DEPTH          = 256,
   parameter int XCLK_DIV       = 2,
   parameter int PWDN_CYCLES    = 1000,
   parameter int RST_CYCLES     = 1000,
   parameter int SETTLE_CYCLES  = 25000,
   parameter int DELAY_UNIT     = CLK_FREQ / 1000,
   parameter int SCCB_TIMEOUT   = 65535,
   localparam int RW            = 8 * REG_ADDR_BYTES,
   localparam int AW            = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clk_en,
   input  logic                   restart,
   camera_init_sequencer_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [AW:0]            write_count,
   output logic                   reset,
   output logic                   pwdn,
   output logic                   xclk
);

   localparam logic [1:0] CMD_WRITE = 2'b00;
   localparam logic [1:0] CMD_DELAY = 2'b01;
   localparam logic [1:0] CMD_END   = 2'b10;

   localparam logic [31:0] PWDN_LAST    = 32'(PWDN_CYCLES - 1);
   localparam logic [31:0] RST_LAST     = 32'(RST_CYCLES - 1);
   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(SCCB_TIMEOUT - 1);
   localparam logic [31:0] XCLK_LAST    = 32'(XCLK_DIV / 2 - 1);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);

   typedef enum logic [3:0] {
      PWR_DOWN,
      RST_ASSERT,
      SETTLE,
      FETCH,
      DECODE,
      WRITE_REQ,
      WRITE_WAIT,
      DELAY,
      ADVANCE,
      DONE
   } state_t;

   state_t        state;
   logic [31:0]   cnt;
   logic          first_wait;
   logic [31:0]   xclk_cnt;

   logic [1:0]    entry_cmd;
   logic [RW-1:0] entry_reg;
   logic [7:0]    entry_data;

   assign entry_cmd  = bus.table_data[RW+9:RW+8];
   assign entry_reg  = bus.table_data[RW+7:8];
   assign entry_data = bus.table_data[7:0];

   // Free-running XCLK divider, independent of the sequencer state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xclk_cnt <= '0;
         xclk     <= 1'b0;
      end else if (clk_en) begin
         if (xclk_cnt == XCLK_LAST) begin
            xclk_cnt <= '0;
            xclk     <= ~xclk;
         end else begin
            xclk_cnt <= xclk_cnt + 32'd1;
         end
      end
   end

   // Sequencer FSM. cnt is shared: power-up phase timer, delay down-counter,
   // and SCCB timeout counter spanning WRITE_REQ plus WRITE_WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= PWR_DOWN;
         cnt               <= '0;
         first_wait        <= 1'b0;
         pwdn              <= 1'b1;
         reset             <= 1'b0;
         bus.sccb_start    <= 1'b0;
         bus.sccb_reg_addr <= '0;
         bus.sccb_data     <= '0;
         bus.table_addr    <= '0;
         write_count       <= '0;
         done              <= 1'b0;
         error             <= 1'b0;
         busy              <= 1'b1;
      end else if (clk_en) begin
         bus.sccb_start <= 1'b0;
         case (state)
            PWR_DOWN: begin
               if (cnt == PWDN_LAST) begin
                  cnt   <= '0;
                  pwdn  <= 1'b0;
                  state <= RST_ASSERT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            RST_ASSERT: begin
               if (cnt == RST_LAST) begin
                  cnt   <= '0;
                  reset <= 1'b1;
                  state <= SETTLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt            <= '0;
                  bus.table_addr <= '0;
                  state          <= FETCH;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            FETCH: begin
               state <= DECODE;
            end
            DECODE: begin
               case (entry_cmd)
                  CMD_WRITE: begin
                     bus.sccb_reg_addr <= entry_reg;
                     bus.sccb_data     <= entry_data;
                     cnt               <= '0;
                     state             <= WRITE_REQ;
                  end
                  CMD_DELAY: begin
                     cnt   <= 32'(entry_data) * 32'(DELAY_UNIT);
                     state <= DELAY;
                  end
                  CMD_END: begin
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end
                  default: begin
                     state <= ADVANCE;
                  end
               endcase
            end
            // The >= compare keeps a start issued on the last allowed cycle
            // from pushing cnt past the timeout value unnoticed.
            WRITE_REQ: begin
               if (bus.sccb_ready) begin
                  bus.sccb_start <= 1'b1;
                  write_count    <= write_count + 1'b1;
                  first_wait     <= 1'b1;
                  cnt            <= cnt + 32'd1;
                  state          <= WRITE_WAIT;
               end else if (cnt >= TIMEOUT_LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  error <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            // The engine cannot have dropped ready yet on the cycle that
            // start is visible, so ready is not trusted on that cycle.
            WRITE_WAIT: begin
               first_wait <= 1'b0;
               if (!first_wait && bus.sccb_ready) begin
                  state <= ADVANCE;
               end else if (cnt >= TIMEOUT_LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  error <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            DELAY: begin
               if (cnt == 32'd0) begin
                  state <= ADVANCE;
               end else begin
                  cnt <= cnt - 32'd1;
               end
            end
            ADVANCE: begin
               if (bus.table_addr == LAST_ADDR) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  error <= 1'b1;
                  state <= DONE;
               end else begin
                  bus.table_addr <= bus.table_addr + 1'b1;
                  state          <= FETCH;
               end
            end
            DONE: begin
               if (restart) begin
                  done           <= 1'b0;
                  busy           <= 1'b1;
                  error          <= 1'b0;
                  write_count    <= '0;
                  bus.table_addr <= '0;
                  state          <= FETCH;
               end
            end
            default: begin
               state <= PWR_DOWN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_camera_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_camera_init_sequencer
//
// Drives camera_init_sequencer with a small table ROM and an SCCB responder
// model. Expected write lists and outcomes are derived from the table with a
// plain walk of the command rules.
// ---------------------------------------------------------------------------
module tb_camera_init_sequencer;

   localparam int TDEPTH = 4;
   localparam int XDIV   = 4;
   localparam int DUNIT  = 10;

   logic        clk;
   logic        rst_n;
   logic        clk_en;
   logic        restart;
   logic        busy;
   logic        done;
   logic        error;
   logic [2:0]  write_count;
   logic        reset;
   logic        pwdn;
   logic        xclk;

   camera_init_sequencer_if #(.RW(16), .AW(2)) bus ();

   camera_init_sequencer #(
      .CLK_FREQ(25000000),
      .REG_ADDR_BYTES(2),
      .DEPTH(TDEPTH),
      .XCLK_DIV(XDIV),
      .PWDN_CYCLES(4),
      .RST_CYCLES(3),
      .SETTLE_CYCLES(5),
      .DELAY_UNIT(DUNIT),
      .SCCB_TIMEOUT(20)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clk_en(clk_en),
      .restart(restart),
      .bus(bus.master),
      .busy(busy),
      .done(done),
      .error(error),
      .write_count(write_count),
      .reset(reset),
      .pwdn(pwdn),
      .xclk(xclk)
   );

   int checks = 0;
   int errors = 0;

   logic [25:0] mem [TDEPTH];
   logic [23:0] exp_w [$];
   logic [23:0] obs_w [$];
   int          obs_cyc [$];
   int          exp_err, exp_wc, exp_addr;

   int   ecyc = 0;
   int   clk_cnt = 0;
   logic last_en = 1'b0;
   logic start_q = 1'b0;
   logic pwdn_q = 1'b1;
   logic reset_q = 1'b0;
   int   pwdn_fall = -1;
   int   reset_rise = -1;
   int   long_pulse = 0;

   int   en_mode = 0;
   int   en_ph = 0;
   logic stuck = 1'b0;
   logic rand_busy = 1'b0;
   int   busy_left = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // clk_en pattern: always on, 1-in-3, or random.
   initial begin
      clk_en = 1'b1;
      forever begin
         @(negedge clk);
         case (en_mode)
            0: clk_en = 1'b1;
            1: begin
               clk_en = (en_ph == 0);
               en_ph  = (en_ph + 1) % 3;
            end
            default: clk_en = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Table ROM: registered read, so data is valid one enabled cycle later.
   always @(posedge clk) begin
      if (clk_en) bus.table_data <= mem[bus.table_addr];
   end

   // SCCB engine model: drops ready after seeing start and stays busy for a
   // number of enabled cycles, or holds ready low when stuck.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sccb_ready <= 1'b1;
         busy_left      <= 0;
      end else if (clk_en) begin
         if (stuck) begin
            bus.sccb_ready <= 1'b0;
         end else if (bus.sccb_start) begin
            bus.sccb_ready <= 1'b0;
            busy_left      <= rand_busy ? int'($urandom_range(1, 10)) : 10;
         end else if (busy_left > 1) begin
            busy_left <= busy_left - 1;
         end else begin
            busy_left      <= 0;
            bus.sccb_ready <= 1'b1;
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecyc <= 0;
      else if (clk_en) ecyc <= ecyc + 1;
   end

   always @(posedge clk) begin
      clk_cnt <= clk_cnt + 1;
      last_en <= clk_en && rst_n;
   end

   // Monitor on the falling edge: power-pin edges and SCCB start pulses.
   always @(negedge clk) begin
      pwdn_q  <= pwdn;
      reset_q <= reset;
      if (rst_n && pwdn_q && !pwdn && pwdn_fall < 0) pwdn_fall <= ecyc;
      if (rst_n && !reset_q && reset && reset_rise < 0) reset_rise <= ecyc;
      if (last_en) begin
         start_q <= bus.sccb_start;
         if (bus.sccb_start) begin
            if (start_q) long_pulse <= long_pulse + 1;
            obs_w.push_back({bus.sccb_reg_addr, bus.sccb_data});
            obs_cyc.push_back(ecyc);
         end
      end
   end

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   function automatic logic [25:0] wr(input logic [15:0] a, input logic [7:0] d);
      return {2'b00, a, d};
   endfunction

   function automatic logic [25:0] dl(input logic [7:0] n);
      return {2'b01, 16'h0000, n};
   endfunction

   function automatic logic [25:0] en_cmd();
      return {2'b10, 24'h000000};
   endfunction

   task automatic load_table(input logic [25:0] e0, input logic [25:0] e1,
                             input logic [25:0] e2, input logic [25:0] e3);
      mem[0] = e0;
      mem[1] = e1;
      mem[2] = e2;
      mem[3] = e3;
   endtask

   // Reference walk: WRITEs are collected in order, END stops cleanly,
   // running off the last entry without END is an error.
   task automatic run_model();
      logic [1:0] c;
      exp_w.delete();
      exp_err  = 0;
      exp_addr = 0;
      for (int i = 0; i < TDEPTH; i++) begin
         c        = mem[i][25:24];
         exp_addr = i;
         if (c == 2'b10) break;
         if (c == 2'b00) exp_w.push_back(mem[i][23:0]);
         if (i == TDEPTH - 1) exp_err = 1;
      end
      exp_wc = exp_w.size();
   endtask

   task automatic compare_run();
      int n;
      check_output("done", done, 1);
      check_output("busy", busy, 0);
      check_output("error", error, exp_err);
      check_output("write_count", write_count, exp_wc);
      check_output("table_addr", bus.table_addr, exp_addr);
      check_output("write_num", obs_w.size(), exp_w.size());
      n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
      for (int i = 0; i < n; i++) check_output("write_entry", obs_w[i], exp_w[i]);
      check_output("pwdn_held", pwdn, 0);
      check_output("reset_held", reset, 1);
   endtask

   // Restart the table from DONE and follow the run to completion.
   task automatic apply_stimulus(input int poke, input bit expect_timeout,
                                 output int en_cyc, output int clk_cyc,
                                 output int first_start);
      int n;
      int r0;
      int c0;
      run_model();
      if (expect_timeout) begin
         exp_w.delete();
         exp_err  = 1;
         exp_wc   = 0;
         exp_addr = 0;
      end
      obs_w.delete();
      obs_cyc.delete();
      @(negedge clk);
      restart = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!clk_en && n < 50);
      @(negedge clk);
      restart = 1'b0;
      r0 = ecyc;
      c0 = clk_cnt;
      for (int i = 0; i < 4000 && !done; i++) begin
         if (poke > 0 && i == poke) begin
            check_output("busy_at_poke", busy, 1);
            restart = 1'b1;
         end
         if (poke > 0 && i == poke + 6) restart = 1'b0;
         @(negedge clk);
      end
      restart     = 1'b0;
      en_cyc      = ecyc - r0;
      clk_cyc     = clk_cnt - c0;
      first_start = (obs_cyc.size() > 0) ? obs_cyc[0] - r0 : -1;
      compare_run();
   endtask

   initial begin
      int en_a, clk_a, en_b, clk_b, fs, gap0, gap5;
      logic [25:0] e [4];
      rst_n     = 1'b0;
      restart   = 1'b0;
      stuck     = 1'b0;
      rand_busy = 1'b0;
      en_mode   = 0;
      load_table(wr(16'h3008, 8'h82), wr(16'h3103, 8'h03), en_cmd(), en_cmd());
      repeat (3) @(negedge clk);

      check_output("rst_pwdn", pwdn, 1);
      check_output("rst_reset", reset, 0);
      check_output("rst_xclk", xclk, 0);
      check_output("rst_start", bus.sccb_start, 0);
      check_output("rst_reg_addr", bus.sccb_reg_addr, 0);
      check_output("rst_data", bus.sccb_data, 0);
      check_output("rst_table_addr", bus.table_addr, 0);
      check_output("rst_write_count", write_count, 0);
      check_output("rst_done", done, 0);
      check_output("rst_error", error, 0);
      check_output("rst_busy", busy, 1);

      // Power-up run straight out of reset with clk_en always on.
      run_model();
      obs_w.delete();
      obs_cyc.delete();
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check_output("xclk", xclk, (ecyc / (XDIV / 2)) % 2);
      end
      for (int k = 0; k < 500 && !done; k++) @(negedge clk);
      compare_run();
      check_output("pwdn_fall_cycle", pwdn_fall, 4);
      check_output("reset_rise_cycle", reset_rise, 7);
      // FETCH at 12, DECODE, WRITE_REQ, then start with ready already high.
      check_output("first_start_cycle", (obs_cyc.size() > 0) ? obs_cyc[0] : -1, 15);

      // Same table re-run from DONE, then again with clk_en 1-in-3.
      apply_stimulus(0, 1'b0, en_a, clk_a, fs);
      en_mode = 1;
      apply_stimulus(0, 1'b0, en_b, clk_b, fs);
      en_mode = 0;
      check_output("slow_en_cycles", en_b, en_a);
      check_output("slow_clk_ratio", (clk_b >= 3 * en_a - 2) && (clk_b <= 3 * en_a + 2), 1);

      // Delay span: DELAY 5 must add exactly 5*DELAY_UNIT over DELAY 0.
      load_table(dl(8'd0), wr(16'h0012, 8'h80), en_cmd(), en_cmd());
      apply_stimulus(0, 1'b0, en_a, clk_a, gap0);
      load_table(dl(8'd5), wr(16'h0012, 8'h80), en_cmd(), en_cmd());
      apply_stimulus(10, 1'b0, en_a, clk_a, gap5);
      check_output("delay_span", gap5 - gap0, 5 * DUNIT);
      check_output("delay_min", gap5 >= 5 * DUNIT, 1);

      // SCCB engine never ready: timeout with no start pulse.
      load_table(wr(16'h0042, 8'h11), en_cmd(), en_cmd(), en_cmd());
      stuck = 1'b1;
      repeat (3) @(negedge clk);
      apply_stimulus(0, 1'b1, en_a, clk_a, fs);
      check_output("timeout_window", (en_a >= 20) && (en_a <= 22), 1);
      stuck = 1'b0;
      repeat (3) @(negedge clk);

      // Overrun: four writes and no END.
      load_table(wr(16'h1111, 8'h01), wr(16'h2222, 8'h02),
                 wr(16'h3333, 8'h03), wr(16'h4444, 8'h04));
      apply_stimulus(0, 1'b0, en_a, clk_a, fs);

      // Randomized tables, engine latency and clk_en pattern.
      rand_busy = 1'b1;
      for (int it = 0; it < 25; it++) begin
         for (int j = 0; j < TDEPTH; j++) begin
            e[j] = {2'($urandom_range(0, 3)), 16'($urandom), 8'($urandom)};
            if (e[j][25:24] == 2'b01) e[j][7:0] = 8'($urandom_range(0, 3));
         end
         load_table(e[0], e[1], e[2], e[3]);
         en_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
         apply_stimulus(0, 1'b0, en_a, clk_a, fs);
      end
      en_mode = 0;
      check_output("start_pulse_width", long_pulse, 0);

      // Reset while a write is pending aborts everything asynchronously.
      load_table(wr(16'h0055, 8'h66), en_cmd(), en_cmd(), en_cmd());
      stuck = 1'b1;
      repeat (3) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      repeat (4) @(negedge clk);
      check_output("pending_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check_output("abort_pwdn", pwdn, 1);
      check_output("abort_reset", reset, 0);
      check_output("abort_busy", busy, 1);
      check_output("abort_done", done, 0);
      check_output("abort_start", bus.sccb_start, 0);
      check_output("abort_reg_addr", bus.sccb_reg_addr, 0);
      check_output("abort_write_count", write_count, 0);
      check_output("abort_xclk", xclk, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/camera_init_sequencer.md
Name: camera_init_sequencer

Overview:
- Parametrised successor to the fixed OV7670 configure block.
- Performs sensor power-up sequencing: PWDN, then RESET, then settle.
- Generates XCLK with a programmable divider.
- Walks a register table with write, delay and end commands, supporting 8- or 16-bit sensor register addresses.
- Drives an external SCCB write engine through a start/ready handshake.
- Sits between the camera pins/SCCB master and the capture pipeline; reports done/error.

Parameters:
- CLK_FREQ, 25000000: clk frequency in Hz (informational; used for the DELAY_UNIT default).
- REG_ADDR_BYTES, 1: sensor register address bytes, 1 or 2. RW = 8*REG_ADDR_BYTES.
- DEPTH, 256: table entries. AW = $clog2(DEPTH).
- XCLK_DIV, 2: even, ≥2. xclk period in enabled cycles.
- PWDN_CYCLES, 1000: enabled cycles pwdn is held high after reset.
- RST_CYCLES, 1000: enabled cycles reset is held low.
- SETTLE_CYCLES, 25000: enabled cycles after reset release before the first fetch.
- DELAY_UNIT, CLK_FREQ/1000: enabled cycles per delay tick (1 ms).
- SCCB_TIMEOUT, 65535: enabled cycles allowed waiting for sccb_ready.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: async active-low reset.
- clk_en, in, 1: all state, counters and xclk advance only when 1.
- restart, in, 1: re-run the table (no power sequencing); sampled on enabled cycles.
- table_addr, out, AW: table index.
- table_data, in, RW+10: entry {cmd[1:0], reg_addr[RW-1:0], data[7:0]}, valid 1 enabled cycle after table_addr.
- sccb_start, out, 1: one-enabled-cycle write request.
- sccb_reg_addr, out, RW: register address, held stable while the write is pending.
- sccb_data, out, 8: register data, held stable while the write is pending.
- sccb_ready, in, 1: SCCB engine idle.
- busy, out, 1: state != DONE.
- done, out, 1: sequence finished (success or error).
- error, out, 1: timeout or table overrun.
- write_count, out, AW+1: SCCB writes issued this run.
- reset, out, 1: sensor RESET, active-low.
- pwdn, out, 1: sensor PWDN, active-high.
- xclk, out, 1: sensor clock.

Behaviour:
- Async reset values:
  - state = PWR_DOWN, pwdn = 1, reset = 0, xclk = 0.
  - sccb_start = 0, sccb_reg_addr = 0, sccb_data = 0.
  - table_addr = 0, write_count = 0.
  - done = 0, error = 0, busy = 1.
- xclk: a free-running divider, independent of the FSM. It toggles every XCLK_DIV/2 enabled cycles. The first toggle comes XCLK_DIV/2 enabled cycles after reset release. XCLK_DIV=2 reproduces toggle-every-enabled-cycle.
- Cycle counts below are enabled cycles. When clk_en=0, every register holds its value.
- PWR_DOWN: pwdn=1, reset=0. After PWDN_CYCLES → RST_ASSERT with pwdn=0.
- RST_ASSERT: reset=0. After RST_CYCLES → SETTLE with reset=1.
- SETTLE: after SETTLE_CYCLES → FETCH with table_addr=0.
- FETCH: present table_addr, wait 1 cycle → DECODE.
- DECODE, by cmd:
  - 00 WRITE: latch reg_addr/data → WRITE_REQ.
  - 01 DELAY: load count = data*DELAY_UNIT → DELAY.
  - 10 END → DONE, error unchanged.
  - 11 NOP → ADVANCE.
- WRITE_REQ: wait for sccb_ready=1, then assert sccb_start for exactly one enabled cycle, increment write_count → WRITE_WAIT.
- WRITE_WAIT:
  - sccb_ready is ignored on the first enabled cycle after start.
  - sccb_ready=1 → ADVANCE.
  - The timeout counter covers WRITE_REQ and WRITE_WAIT combined. Reaching SCCB_TIMEOUT → DONE with error=1.
- DELAY: count down to 0 → ADVANCE. data=0 gives a zero-length delay (advance on the next cycle).
- ADVANCE:
  - If table_addr == DEPTH-1 (no END seen) → DONE with error=1; no wrap.
  - Otherwise table_addr+1 → FETCH.
- DONE: done=1, busy=0.
  - restart=1 → FETCH. Clears done, error and write_count; table_addr=0. pwdn/reset are untouched.
  - restart in any other state is ignored.
- sccb_reg_addr/sccb_data change only in DECODE of a WRITE entry.
- Reset mid-operation aborts immediately to reset values, including a pending SCCB write.

Test Plan:
- PWDN_CYCLES=4, RST_CYCLES=3, SETTLE_CYCLES=5, clk_en every cycle → pwdn falls at cycle 4, reset rises at cycle 7, first table_addr fetch at cycle 12. XCLK_DIV=4 → xclk period 4 cycles.
- REG_ADDR_BYTES=2, table {WR 0x3008/0x82, WR 0x3103/0x03, END}, ready model drops 1 cycle after start for 10 cycles → two single-cycle sccb_start pulses with addr/data 0x3008/0x82 then 0x3103/0x03; done=1, error=0, write_count=2.
- DELAY_UNIT=10, table {DELAY 5, WR 0x12/0x80, END} → sccb_start ≥50 enabled cycles after the DELAY decode. DELAY 0 adds no wait.
- sccb_ready stuck low, SCCB_TIMEOUT=20 → no sccb_start pulse; done=1, error=1 by 20 cycles after WRITE_REQ entry.
- DEPTH=4, four WRITE entries and no END → 4 writes, then done=1, error=1, table_addr=3.
- clk_en toggling 1-in-3 with the second scenario → identical sequence, 3× slower. restart in DONE → the table re-runs with write_count reset and pwdn/reset unchanged. restart while busy → ignored.
